// File: rtl/logger_uart_tx_if.sv
// rtl/logger_uart_tx_if.sv - FWFT FIFO read-port bundle between logger FIFO and UART TX
interface logger_uart_tx_if;
    logic [7:0] fifo_dout;
    logic       fifo_empty;
    logic       fifo_rd_rst_busy;
    logic       fifo_rd_en;

    modport master (
        input  fifo_dout,
        input  fifo_empty,
        input  fifo_rd_rst_busy,
        output fifo_rd_en
    );

    modport slave (
        output fifo_dout,
        output fifo_empty,
        output fifo_rd_rst_busy,
        input  fifo_rd_en
    );
endinterface

// File: rtl/logger_uart_tx.sv
// rtl/logger_uart_tx.sv - drains the logger FWFT FIFO onto a UART TX line (8N1/8N2)
// Optional even parity bit (8E1/8E2) when LOGGER_UART_PARITY_EN is defined.
module logger_uart_tx #(
    parameter int CLK_FREQ_HZ  = 100_000_000,
    parameter int BAUD         = 115_200,
    parameter int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD,
    parameter int STOP_BITS    = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    tx_enable,
    logger_uart_tx_if.master        fifo,
    output logic                    uart_txd,
    output logic                    busy,
    output logic [15:0]             bytes_sent
);

    generate
        if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
            $error("logger_uart_tx: CLKS_PER_BIT must be >= 2");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
            $error("logger_uart_tx: STOP_BITS must be 1 or 2");
        end
    endgenerate

    localparam int CW = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);

`ifdef LOGGER_UART_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t        state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          pop;
    logic          bit_end;
`ifdef LOGGER_UART_PARITY_EN
    logic          parity;
`endif

    // Pop is combinational so the FWFT head byte is captured on the same edge it is consumed.
    assign pop = (state == IDLE) & tx_enable & ~fifo.fifo_empty & ~fifo.fifo_rd_rst_busy & rst_n;
    assign fifo.fifo_rd_en = pop;
    assign bit_end = (baud_cnt == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            uart_txd   <= 1'b1;
            busy       <= 1'b0;
            bytes_sent <= 16'h0000;
            shift      <= 8'h00;
            baud_cnt   <= '0;
            bit_idx    <= 3'd0;
`ifdef LOGGER_UART_PARITY_EN
            parity     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        shift    <= fifo.fifo_dout;
                        state    <= START;
                        busy     <= 1'b1;
                        uart_txd <= 1'b0;
                        baud_cnt <= '0;
                        bit_idx  <= 3'd0;
`ifdef LOGGER_UART_PARITY_EN
                        parity   <= ^fifo.fifo_dout;
`endif
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        state    <= DATA;
                        uart_txd <= shift[0];
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            bit_idx  <= 3'd0;
`ifdef LOGGER_UART_PARITY_EN
                            state    <= PARITY;
                            uart_txd <= parity;
`else
                            state    <= STOP;
                            uart_txd <= 1'b1;
`endif
                        end else begin
                            // Shift keeps the next data bit in position 1 for the upcoming boundary.
                            bit_idx  <= bit_idx + 3'd1;
                            uart_txd <= shift[1];
                            shift    <= {1'b0, shift[7:1]};
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`ifdef LOGGER_UART_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        state    <= STOP;
                        uart_txd <= 1'b1;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'(STOP_BITS - 1)) begin
                            bit_idx    <= 3'd0;
                            state      <= IDLE;
                            busy       <= 1'b0;
                            bytes_sent <= bytes_sent + 16'd1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    uart_txd <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_logger_uart_tx.sv
// tb/tb_logger_uart_tx.sv - directed self-checking bench for logger_uart_tx
// Parity scenario is compiled in when LOGGER_UART_PARITY_EN is defined.
module tb_logger_uart_tx;

    localparam int CPB = 10;
`ifdef LOGGER_UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tx_enable;
    logic        uart_txd;
    logic        busy;
    logic [15:0] bytes_sent;

    logger_uart_tx_if fif ();

    logic [7:0] mem [16];
    logic [3:0] wr_ptr = 4'd0;
    logic [3:0] rd_ptr = 4'd0;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_pass = 0;

    assign fif.fifo_dout  = mem[rd_ptr];
    assign fif.fifo_empty = (wr_ptr == rd_ptr);

    logger_uart_tx #(
        .CLK_FREQ_HZ(1_000_000),
        .BAUD(100_000),
        .STOP_BITS(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .tx_enable(tx_enable),
        .fifo(fif),
        .uart_txd(uart_txd),
        .busy(busy),
        .bytes_sent(bytes_sent)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fif.fifo_rd_en) rd_ptr <= rd_ptr + 4'd1;
    end

    task automatic check(input string name, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 4'd1;
    endtask

    function automatic logic exp_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (k == 9 && NB == 11) return ^b;
        return 1'b1;
    endfunction

    task automatic wait_pop(output int pop_cyc);
        int n;
        n = 0;
        #1;
        while (fif.fifo_rd_en !== 1'b1 && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("pop_seen", {15'd0, fif.fifo_rd_en}, 16'd1);
        pop_cyc = cyc;
    endtask

    // Walks one frame cycle-by-cycle from the pop; optional tx_enable drop or reset at a frame cycle.
    task automatic send_check(input logic [7:0] b, input int drop_at, input int rst_at,
                              output int pop_cyc);
        wait_pop(pop_cyc);
        for (int i = 0; i < NB * CPB; i++) begin
            @(negedge clk);
            #1;
            if (i == rst_at) begin
                rst_n = 1'b0;
                #1;
                check("rst_txd", {15'd0, uart_txd}, 16'd1);
                check("rst_busy", {15'd0, busy}, 16'd0);
                check("rst_bytes", bytes_sent, 16'd0);
                check("rst_rd_en", {15'd0, fif.fifo_rd_en}, 16'd0);
                return;
            end
            check("frame_txd", {15'd0, uart_txd}, {15'd0, exp_bit(b, i / CPB)});
            check("frame_busy", {15'd0, busy}, 16'd1);
            check("frame_rd_en", {15'd0, fif.fifo_rd_en}, 16'd0);
            if (i == drop_at) tx_enable = 1'b0;
        end
        @(negedge clk);
        #1;
        check("gap_busy", {15'd0, busy}, 16'd0);
        check("gap_txd", {15'd0, uart_txd}, 16'd1);
    endtask

    initial begin
        int p0, p1, p2;
        rst_n = 1'b0;
        tx_enable = 1'b0;
        fif.fifo_rd_rst_busy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("reset_txd", {15'd0, uart_txd}, 16'd1);
        check("reset_busy", {15'd0, busy}, 16'd0);
        check("reset_bytes", bytes_sent, 16'd0);
        check("reset_rd_en", {15'd0, fif.fifo_rd_en}, 16'd0);
        rst_n = 1'b1;

        // 1: single byte
        push(8'hA5);
        tx_enable = 1'b1;
        send_check(8'hA5, -1, -1, p0);
        check("s1_bytes", bytes_sent, 16'd1);
        check("s1_empty", {15'd0, fif.fifo_empty}, 16'd1);

        // 2: back-to-back frames
        @(negedge clk);
        tx_enable = 1'b0;
        push(8'h00);
        push(8'hFF);
        push(8'h55);
        tx_enable = 1'b1;
        send_check(8'h00, -1, -1, p0);
        send_check(8'hFF, -1, -1, p1);
        send_check(8'h55, -1, -1, p2);
        check("s2_gap01", 16'(p1 - p0), 16'd101);
        check("s2_gap12", 16'(p2 - p1), 16'd101);
        check("s2_bytes", bytes_sent, 16'd4);
        check("s2_empty", {15'd0, fif.fifo_empty}, 16'd1);

        // 3: FIFO read side still in reset
        @(negedge clk);
        fif.fifo_rd_rst_busy = 1'b1;
        push(8'h5A);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            check("s3_rd_en", {15'd0, fif.fifo_rd_en}, 16'd0);
            check("s3_txd", {15'd0, uart_txd}, 16'd1);
        end
        fif.fifo_rd_rst_busy = 1'b0;
        #1;
        check("s3_pop_on_fall", {15'd0, fif.fifo_rd_en}, 16'd1);
        send_check(8'h5A, -1, -1, p0);
        check("s3_bytes", bytes_sent, 16'd5);

        // 4: tx_enable dropped mid-frame
        @(negedge clk);
        tx_enable = 1'b0;
        push(8'h3C);
        push(8'h81);
        tx_enable = 1'b1;
        send_check(8'h3C, 30, -1, p0);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            #1;
            check("s4_hold_rd_en", {15'd0, fif.fifo_rd_en}, 16'd0);
            check("s4_hold_txd", {15'd0, uart_txd}, 16'd1);
        end
        check("s4_bytes", bytes_sent, 16'd6);
        check("s4_not_empty", {15'd0, fif.fifo_empty}, 16'd0);
        tx_enable = 1'b1;
        send_check(8'h81, -1, -1, p0);
        check("s4_bytes2", bytes_sent, 16'd7);

        // 5: reset mid-frame, popped byte lost
        @(negedge clk);
        tx_enable = 1'b0;
        push(8'h96);
        push(8'h4B);
        tx_enable = 1'b1;
        send_check(8'h96, -1, 45, p0);
        @(negedge clk);
        rst_n = 1'b1;
        send_check(8'h4B, -1, -1, p0);
        check("s5_bytes", bytes_sent, 16'd1);
        check("s5_empty", {15'd0, fif.fifo_empty}, 16'd1);

`ifdef LOGGER_UART_PARITY_EN
        // 6: even parity
        @(negedge clk);
        tx_enable = 1'b0;
        push(8'h07);
        push(8'h03);
        tx_enable = 1'b1;
        send_check(8'h07, -1, -1, p0);
        send_check(8'h03, -1, -1, p1);
        check("s6_len", 16'(p1 - p0), 16'd111);
        check("s6_bytes", bytes_sent, 16'd3);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/logger_uart_tx.md
Name: logger_uart_tx

Overview:
Read-side consumer of the logger byte FIFO. It drains bytes from the first-word-fall-through sync FIFO and serialises each one onto a UART TX line as 8N1, with an optional parity bit. It sits between the logger FIFO read port and the board UART pin, in the same clock domain as the FIFO.

Parameters:
CLK_FREQ_HZ, 100_000_000, system clock frequency in Hz
BAUD, 115_200, line rate in bit/s
CLKS_PER_BIT, CLK_FREQ_HZ/BAUD (integer divide), clocks per UART bit; elaboration error if < 2
STOP_BITS, 1, number of stop bits; legal values 1 or 2 only, elaboration error otherwise

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
tx_enable  input  1  permits starting new frames; the current frame always completes
fifo_dout  input  8  FIFO head byte, FWFT, valid while fifo_empty=0
fifo_empty  input  1  FIFO empty flag
fifo_rd_rst_busy  input  1  FIFO read side still in reset; no pops allowed
fifo_rd_en  output  1  pop strobe to the FIFO
uart_txd  output  1  serial line, idle high
busy  output  1  high from the pop cycle until the end of the last stop bit
bytes_sent  output  16  count of completed frames, wraps 0xFFFF->0x0000

Behaviour:
- Reset state while rst_n=0: state=IDLE, uart_txd=1, busy=0, bytes_sent=0, fifo_rd_en=0, shift register=0, baud counter=0, bit index=0.
- fifo_rd_en is combinational: (state==IDLE) & tx_enable & !fifo_empty & !fifo_rd_rst_busy & rst_n. It is never high for two consecutive cycles.
- On the pop edge:
  - fifo_dout is latched into the shift register.
  - State goes to START and busy=1.
  - uart_txd=0 from the next cycle, so latency from pop to start-bit edge is 1 clock.
- State machine and exits:
  - IDLE: exits to START only on a pop.
  - START: holds CLKS_PER_BIT cycles, then goes to DATA.
  - DATA: sends 8 bits LSB first, each held CLKS_PER_BIT cycles, then goes to PARITY (feature on) or STOP.
  - PARITY (feature on only): holds CLKS_PER_BIT cycles, then goes to STOP.
  - STOP: uart_txd=1 for STOP_BITS*CLKS_PER_BIT cycles, then goes to IDLE.
- uart_txd is registered, so there are no glitches.
- Baud counter: counts 0..CLKS_PER_BIT-1 and reloads to 0 on each bit boundary. Its width is $clog2(CLKS_PER_BIT).
- On the last STOP cycle:
  - bytes_sent increments (modulo 2^16).
  - busy drops and state returns to IDLE.
- Back-to-back frames: if the FIFO is still non-empty, the pop occurs in the first IDLE cycle. The minimum idle gap between frames is therefore 1 clock (the pop cycle); uart_txd stays 1 during it.
- tx_enable falling mid-frame: the frame completes normally, and no further pop happens until tx_enable is high again.
- fifo_empty rising mid-frame: no effect on the current frame.
- fifo_rd_rst_busy=1 while IDLE: no pop; the block waits.
- rst_n asserted mid-frame: the frame is aborted immediately (asynchronously) and uart_txd=1. A byte that was already popped is lost, and bytes_sent is cleared.
- Reset release: the first pop can occur on the first clock edge after rst_n=1, subject to the pop conditions.

Optional Feature:
LOGGER_UART_PARITY_EN
- Defined: a PARITY state is inserted after DATA and sends even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles. The frame becomes 8E1/8E2.
- Undefined: no PARITY state and no parity logic; the frame is 8N1/8N2.
- bytes_sent and busy semantics are unchanged in both builds.

Test Plan:
- Common overrides for all scenarios: CLK_FREQ_HZ=1_000_000, BAUD=100_000 (CLKS_PER_BIT=10), STOP_BITS=1; FIFO model is FWFT.
1. Single byte 0xA5, tx_enable=1 -> one fifo_rd_en pulse; txd low 10 clk; bits 1,0,1,0,0,1,0,1 at 10 clk each; high 10 clk; busy high 100 clk; bytes_sent=1.
2. FIFO preloaded with 0x00, 0xFF, 0x55 -> three frames with a 1-clock idle gap each; pops exactly 101 clk apart; bytes_sent=3; FIFO empty at end.
3. fifo_rd_rst_busy=1 for 20 clk with the FIFO non-empty -> no fifo_rd_en and txd=1 throughout; the first pop happens in the cycle rd_rst_busy falls.
4. tx_enable dropped at clk 30 of a 0x3C frame -> frame completes (100 clk); no further pop while the FIFO holds 0x81; re-enable -> 0x81 is sent next.
5. rst_n pulsed low at clk 45 of a frame -> txd=1 and busy=0 immediately; bytes_sent=0; after release, the next FIFO byte is sent correctly.
6. With LOGGER_UART_PARITY_EN defined: send 0x07 -> parity bit=1; send 0x03 -> parity bit=0; frame length 110 clk.
